buscador_binario: RTL and testbench

//   Sequential initiator that drives a magnitude comparator. It binary-searches for an

---
 rtl/buscador_binario.sv | 141 ++++++++++++++
 tb/tb_buscador_binario.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/buscador_binario.sv
// Binary-search initiator: drives palpite into an external magnitude
// comparator and narrows [low,high] from its iguais/maior/menor flags.
// Ports: clk, rst (async, active-high), start; comparator flags iguais,
// maior, menor in; palpite (operand A), ocupado, pronto (1-cycle pulse),
// resultado, encontrado, erro, tentativas out (last four held per search).
module buscador_binario #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         iguais,
  input  logic                         maior,
  input  logic                         menor,
  output logic [WIDTH-1:0]             palpite,
  output logic                         ocupado,
  output logic                         pronto,
  output logic [WIDTH-1:0]             resultado,
  output logic                         encontrado,
  output logic                         erro,
  output logic [$clog2(WIDTH+2)-1:0]   tentativas
);

  localparam int TW = $clog2(WIDTH+2);
  localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TONE =
    {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             enc_q, enc_d;
  logic             erro_q, erro_d;
  logic [TW-1:0]    tent_q, tent_d;
  logic [WIDTH:0]   soma;

  // One extra bit so low+high never wraps.
  assign soma    = {1'b0, low_q} + {1'b0, high_q};
  assign palpite = soma[WIDTH:1];

  assign ocupado    = (state_q == COMPARA);
  assign pronto     = (state_q == FIM);
  assign resultado  = res_q;
  assign encontrado = enc_q;
  assign erro       = erro_q;
  assign tentativas = tent_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OCIOSO;
      low_q   <= '0;
      high_q  <= '0;
      res_q   <= '0;
      enc_q   <= 1'b0;
      erro_q  <= 1'b0;
      tent_q  <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      high_q  <= high_d;
      res_q   <= res_d;
      enc_q   <= enc_d;
      erro_q  <= erro_d;
      tent_q  <= tent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    high_d  = high_q;
    res_d   = res_q;
    enc_d   = enc_q;
    erro_d  = erro_q;
    tent_d  = tent_q;
    case (state_q)
      OCIOSO: begin
        if (start) begin
          low_d   = '0;
          high_d  = MAXV;
          tent_d  = '0;
          enc_d   = 1'b0;
          erro_d  = 1'b0;
          state_d = COMPARA;
        end
      end
      COMPARA: begin
        tent_d = tent_q + TONE;
        case ({iguais, maior, menor})
          3'b100: begin
            res_d   = palpite;
            enc_d   = 1'b1;
            state_d = FIM;
          end
          3'b010: begin
            // palpite==low also covers palpite==0
            if (palpite == low_q ||
                palpite == '0) begin
              res_d   = palpite;
              erro_d  = 1'b1;
              state_d = FIM;
            end else begin
              high_d = palpite - ONE;
            end
          end
          3'b001: begin
            if (palpite == MAXV ||
                palpite == high_q) begin
              res_d   = palpite;
              erro_d  = 1'b1;
              state_d = FIM;
            end else begin
              low_d = palpite + ONE;
            end
          end
          default: begin
            res_d   = palpite;
            erro_d  = 1'b1;
            state_d = FIM;
          end
        endcase
      end
      FIM: begin
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_buscador_binario.sv
// Self-checking bench for buscador_binario (WIDTH=4) with a behavioural
// comparator and a plain-arithmetic binary-search reference model.
module tb_buscador_binario;

  localparam int W  = 4;
  localparam int TW = $clog2(W+2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          iguais, maior, menor;
  logic [W-1:0]  palpite, resultado;
  logic          ocupado, pronto;
  logic          encontrado, erro;
  logic [TW-1:0] tentativas;

  int   segredo;
  bit   ovr;
  logic [2:0] ovr_f;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int got_q[$];

  buscador_binario #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .iguais     (iguais),
    .maior      (maior),
    .menor      (menor),
    .palpite    (palpite),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .resultado  (resultado),
    .encontrado (encontrado),
    .erro       (erro),
    .tentativas (tentativas)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (ovr) begin
      {iguais, maior, menor} = ovr_f;
    end else begin
      iguais = (int'(palpite) == segredo);
      maior  = (int'(palpite) >  segredo);
      menor  = (int'(palpite) <  segredo);
    end
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Expected guess sequence for a consistent comparator.
  task automatic model(int s);
    int lo, hi, g;
    exp_q.delete();
    lo = 0;
    hi = (1 << W) - 1;
    for (int n = 0; n < 2*W + 2; n++) begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      if (g == s) break;
      if (g > s) hi = g - 1;
      else       lo = g + 1;
    end
  endtask

  // Called at a negedge where start has just been set.
  task automatic collect(bit hold);
    bit done;
    done = 1'b0;
    got_q.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (ocupado) got_q.push_back(int'(palpite));
      if (pronto) begin
        done = 1'b1;
        break;
      end
    end
    chk("pronto_timeout", 32'(done), 32'd1);
  endtask

  task automatic search(string tag, int s, bit hold);
    segredo = s;
    start   = 1'b1;
    model(s);
    collect(hold);
    chk({tag, "_res"}, 32'(resultado), 32'(s));
    chk({tag, "_enc"}, 32'(encontrado), 32'd1);
    chk({tag, "_erro"}, 32'(erro), 32'd0);
    chk({tag, "_tent"}, 32'(tentativas),
        32'(exp_q.size()));
    chk({tag, "_nguess"}, 32'(got_q.size()),
        32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        chk({tag, "_guess"}, 32'(got_q[i]),
            32'(exp_q[i]));
    end
    @(negedge clk);
    chk({tag, "_pulse1"}, 32'(pronto), 32'd0);
    chk({tag, "_hold"}, 32'(resultado), 32'(s));
  endtask

  initial begin
    int np;
    bit seen;
    rst     = 1'b1;
    start   = 1'b0;
    ovr     = 1'b0;
    ovr_f   = 3'b000;
    segredo = 0;
    repeat (2) @(negedge clk);
    chk("rst_palpite", 32'(palpite), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_res", 32'(resultado), 32'd0);
    chk("rst_enc", 32'(encontrado), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    chk("rst_tent", 32'(tentativas), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ocupado", 32'(ocupado), 32'd0);

    search("s7", 7, 1'b0);
    chk("s7_tent1", 32'(tentativas), 32'd1);
    search("s0", 0, 1'b0);
    search("s15", 15, 1'b0);

    for (int s = 0; s < 16; s++)
      search("sweep", s, 1'b1);
    start = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 8; r++)
      search("rand", int'($urandom_range(0, 15)), 1'b0);

    // Inconsistent flags on the very first compare.
    ovr   = 1'b1;
    ovr_f = 3'b011;
    start = 1'b1;
    collect(1'b0);
    chk("bad_erro", 32'(erro), 32'd1);
    chk("bad_enc", 32'(encontrado), 32'd0);
    chk("bad_res", 32'(resultado), 32'd7);
    chk("bad_tent", 32'(tentativas), 32'd1);
    chk("bad_nguess", 32'(got_q.size()), 32'd1);
    ovr = 1'b0;
    @(negedge clk);
    chk("bad_pulse1", 32'(pronto), 32'd0);

    // Abort mid-search once palpite reaches 3.
    segredo = 0;
    start   = 1'b1;
    seen    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (ocupado && palpite == 4'd3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_reach3", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_palpite", 32'(palpite), 32'd0);
    np = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pronto) np++;
    end
    chk("abort_nopronto", 32'(np), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    search("after_rst", 12, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
